// File: rtl/data_pack_pkg.sv
// Shared constants for the feature-SRAM pack/unpack pair: channel count,
// byte-lane positions inside a 16-bit word, and the packer FSM encoding.
package data_pack_pkg;

    localparam int CHANNEL_OUT = 2;

    // Bit positions of the two bytes inside each 16-bit channel word.
    localparam int FRONT_HI = 15;
    localparam int BACK_HI  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRONT = 2'd1,
        ST_BACK  = 2'd2
    } pack_state_e;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_FRONT = 2'd1;
    localparam logic [1:0] STATE_BACK  = 2'd2;

endpackage

// File: rtl/pack_lane.sv
// One channel of the packer: merges a front byte and a back byte into a
// 16-bit word, optionally forcing the back byte to zero (odd row tail).
module pack_lane
    import data_pack_pkg::*;
(
    input  logic [7:0]  front_byte,
    input  logic [7:0]  back_byte,
    input  logic        zero_back,
    output logic [15:0] word
);

    always_comb begin
        word                = '0;
        word[FRONT_HI -: 8] = front_byte;
        word[BACK_HI  -: 8] = zero_back ? 8'h00 : back_byte;
    end

endmodule

// File: rtl/data_pack.sv
// Write-side packer: pairs consecutive pixels of a row into one 16-bit-per-
// channel SRAM word and drives the strobe/address of the selected ping-pong SRAM.
module data_pack
    import data_pack_pkg::*;
#(
    parameter int CH     = CHANNEL_OUT,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sram_sel,
    input  logic [COL_W-1:0]  row_len,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              in_valid,
    input  logic [CH*8-1:0]   in_data,
    output logic              in_ready,
    output logic              wen1,
    output logic              wen2,
    output logic [ADDR_W-1:0] waddr,
    output logic [CH*16-1:0]  wdata,
    output logic              busy,
    output logic              done
);

    pack_state_e       state_q, state_d;
    logic              sel_q, sel_d;
    logic [COL_W-1:0]  row_len_q, row_len_d;
    logic [ROW_W-1:0]  num_rows_q, num_rows_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CH*8-1:0]   front_q, front_d;
    logic              wen1_q, wen1_d;
    logic              wen2_q, wen2_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [CH*16-1:0]  wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              in_front;
    logic              accept;
    logic              start_ok;
    logic              last_pix;
    logic              last_row;
    logic              issue_write;
    logic [CH*16-1:0]  packed_word;

    assign in_ready = (state_q != ST_IDLE);
    assign in_front = (state_q == ST_FRONT);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state_q == ST_IDLE) && !busy_q;
    assign last_pix = (col_q + COL_W'(1)) == row_len_q;
    assign last_row = (row_q + ROW_W'(1)) == num_rows_q;

    // In FRONT a write only happens for an odd row's lone pixel, which is
    // taken straight from the input with the back byte zeroed.
    for (genvar i = 0; i < CH; i++) begin : g_lane
        pack_lane u_lane (
            .front_byte (in_front ? in_data[(i+1)*8-1 -: 8] : front_q[(i+1)*8-1 -: 8]),
            .back_byte  (in_data[(i+1)*8-1 -: 8]),
            .zero_back  (in_front),
            .word       (packed_word[(i+1)*16-1 -: 16])
        );
    end

    always_comb begin
        // NOTE: every _d gets a default up front so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        sel_d       = sel_q;
        row_len_d   = row_len_q;
        num_rows_d  = num_rows_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        front_d     = front_q;
        wen1_d      = 1'b0;
        wen2_d      = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        issue_write = 1'b0;

        if (done_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d    = ST_FRONT;
                    sel_d      = sram_sel;
                    row_len_d  = row_len;
                    num_rows_d = num_rows;
                    col_d      = '0;
                    row_d      = '0;
                    addr_d     = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_FRONT: begin
                if (accept) begin
                    front_d = in_data;
                    if (last_pix) begin
                        issue_write = 1'b1;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = ST_BACK;
                    end
                end
            end
            ST_BACK: begin
                if (accept) begin
                    issue_write = 1'b1;
                    if (!last_pix) begin
                        col_d   = col_q + COL_W'(1);
                        state_d = ST_FRONT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue_write) begin
            wen1_d  = !sel_q;
            wen2_d  = sel_q;
            waddr_d = addr_q;
            wdata_d = packed_word;
            addr_d  = addr_q + ADDR_W'(1);
            // Rows never share a word: a completed row restarts at the front byte.
            if (last_pix) begin
                col_d = '0;
                if (last_row) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = ST_FRONT;
                end
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            row_len_q  <= '0;
            num_rows_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            front_q    <= '0;
            wen1_q     <= 1'b0;
            wen2_q     <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            row_len_q  <= row_len_d;
            num_rows_q <= num_rows_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            front_q    <= front_d;
            wen1_q     <= wen1_d;
            wen2_q     <= wen2_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wen1  = wen1_q;
    assign wen2  = wen2_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_data_pack.sv
// Directed bench for data_pack (CH=2): a per-cycle vector table for the
// frame scenarios, plus a hand-written reset-mid-frame sequence.
module tb_data_pack;

    localparam int CH     = 2;
    localparam int COL_W  = 8;
    localparam int ROW_W  = 8;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              sram_sel;
    logic [COL_W-1:0]  row_len;
    logic [ROW_W-1:0]  num_rows;
    logic              in_valid;
    logic [CH*8-1:0]   in_data;
    logic              in_ready;
    logic              wen1;
    logic              wen2;
    logic [ADDR_W-1:0] waddr;
    logic [CH*16-1:0]  wdata;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    data_pack #(
        .CH     (CH),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sram_sel (sram_sel),
        .row_len  (row_len),
        .num_rows (num_rows),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wen1     (wen1),
        .wen2     (wen2),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done)
    );

    // Output bundle: {in_ready, wen1, wen2, waddr[11:0], wdata[31:0], busy, done}
    typedef struct {
        logic        start;
        logic        sel;
        logic [7:0]  rl;
        logic [7:0]  nr;
        logic        vld;
        logic [15:0] din;
        logic [48:0] exp_out;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [48:0] outs();
        return {in_ready, wen1, wen2, waddr, wdata, busy, done};
    endfunction

    task automatic check(input string name, input logic [48:0] got, input logic [48:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got rdy=%b w1=%b w2=%b addr=%h data=%h busy=%b done=%b, expected rdy=%b w1=%b w2=%b addr=%h data=%h busy=%b done=%b",
                     name, got[48], got[47], got[46], got[45:34], got[33:2], got[1], got[0],
                     exp[48], exp[47], exp[46], exp[45:34], exp[33:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic st, input logic sel, input logic [7:0] rl, input logic [7:0] nr,
                       input logic vld, input logic [15:0] din,
                       input logic rdy, input logic w1, input logic w2, input logic [11:0] wa,
                       input logic [31:0] wd, input logic bsy, input logic dn);
        vec_t v;
        v.start   = st;
        v.sel     = sel;
        v.rl      = rl;
        v.nr      = nr;
        v.vld     = vld;
        v.din     = din;
        v.exp_out = {rdy, w1, w2, wa, wd, bsy, dn};
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        start    = 1'b0;
        sram_sel = 1'b0;
        row_len  = '0;
        num_rows = '0;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Even row, row_len=4, SRAM1; start pulses mid-frame and in the done cycle are ignored.
        //   st sel rl    nr    vld din       rdy w1 w2 addr     wdata          busy done
        add(1, 0, 8'd4, 8'd1, 0, 16'h0000,  1, 0, 0, 12'd0, 32'h0000_0000, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'hA111,  1, 0, 0, 12'd0, 32'h0000_0000, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'hA222,  1, 1, 0, 12'd0, 32'hA1A2_1122, 1, 0);
        add(1, 1, 8'd1, 8'd1, 1, 16'hA333,  1, 0, 0, 12'd0, 32'hA1A2_1122, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'hA444,  0, 1, 0, 12'd1, 32'hA3A4_3344, 1, 1);
        add(1, 1, 8'd1, 8'd1, 1, 16'h5555,  0, 0, 0, 12'd1, 32'hA3A4_3344, 0, 0);
        // Odd rows: row_len=3, num_rows=2, SRAM2; start lands in the cycle busy falls.
        add(1, 1, 8'd3, 8'd2, 0, 16'h0000,  1, 0, 0, 12'd1, 32'hA3A4_3344, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'h8101,  1, 0, 0, 12'd1, 32'hA3A4_3344, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'h8202,  1, 0, 1, 12'd0, 32'h8182_0102, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'h8303,  1, 0, 1, 12'd1, 32'h8300_0300, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'h8404,  1, 0, 0, 12'd1, 32'h8300_0300, 1, 0);
        add(0, 0, 8'd0, 8'd0, 0, 16'hFFFF,  1, 0, 0, 12'd1, 32'h8300_0300, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'h8505,  1, 0, 1, 12'd2, 32'h8485_0405, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'h8606,  0, 0, 1, 12'd3, 32'h8600_0600, 1, 1);
        add(0, 0, 8'd0, 8'd0, 0, 16'h0000,  0, 0, 0, 12'd3, 32'h8600_0600, 0, 0);
        // Gapped input, row_len=2, valid 1,0,1,0.
        add(1, 0, 8'd2, 8'd1, 0, 16'h0000,  1, 0, 0, 12'd3, 32'h8600_0600, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'h1234,  1, 0, 0, 12'd3, 32'h8600_0600, 1, 0);
        add(0, 0, 8'd0, 8'd0, 0, 16'hEEEE,  1, 0, 0, 12'd3, 32'h8600_0600, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'h5678,  0, 1, 0, 12'd0, 32'h1256_3478, 1, 1);
        add(0, 0, 8'd0, 8'd0, 0, 16'h0000,  0, 0, 0, 12'd0, 32'h1256_3478, 0, 0);
        // Minimum frame: row_len=1, num_rows=3, SRAM2, back-to-back writes.
        add(1, 1, 8'd1, 8'd3, 0, 16'h0000,  1, 0, 0, 12'd0, 32'h1256_3478, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'hC1D1,  1, 0, 1, 12'd0, 32'hC100_D100, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'hC2D2,  1, 0, 1, 12'd1, 32'hC200_D200, 1, 0);
        add(0, 0, 8'd0, 8'd0, 1, 16'hC3D3,  0, 0, 1, 12'd2, 32'hC300_D300, 1, 1);
        add(0, 0, 8'd0, 8'd0, 1, 16'hC4D4,  0, 0, 0, 12'd2, 32'hC300_D300, 0, 0);

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 check("reset_values", outs(), 49'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("idle_after_reset", outs(), 49'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start    = vecs[i].start;
            sram_sel = vecs[i].sel;
            row_len  = vecs[i].rl;
            num_rows = vecs[i].nr;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].din;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), outs(), vecs[i].exp_out);
        end
        @(negedge clk) drive_idle();

        // Reset mid-frame: row_len=8, abort after 3 pixels.
        @(negedge clk);
        start = 1'b1; sram_sel = 1'b0; row_len = 8'd8; num_rows = 8'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 16'h0101;
        @(negedge clk) in_data = 16'h0202;
        @(negedge clk) in_data = 16'h0303;
        @(negedge clk) in_valid = 1'b0;
        check("midframe_state", outs(), {1'b1, 1'b0, 1'b0, 12'd0, 32'h0102_0102, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 check("async_reset_clears", outs(), 49'd0);
        @(negedge clk) rst_n = 1'b1;

        // Clean frame after reset: row_len=2 must write address 0.
        @(negedge clk);
        start = 1'b1; sram_sel = 1'b0; row_len = 8'd2; num_rows = 8'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 16'h1A1B;
        @(posedge clk);
        #1 check("post_reset_front", outs(), {1'b1, 1'b0, 1'b0, 12'd0, 32'h0000_0000, 1'b1, 1'b0});
        @(negedge clk) in_data = 16'h2A2B;
        @(posedge clk);
        #1 check("post_reset_write", outs(), {1'b0, 1'b1, 1'b0, 12'd0, 32'h1A2A_1B2B, 1'b1, 1'b1});
        @(negedge clk) drive_idle();
        @(posedge clk);
        #1 check("post_reset_idle", outs(), {1'b0, 1'b0, 1'b0, 12'd0, 32'h1A2A_1B2B, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
